alu_muldiv: RTL

//  Iterative RV32M multiply/divide unit, parametrised successor of the single-cycle integer ALU.

---
 rtl/alu_muldiv_if.sv | 25 ++
 rtl/alu_muldiv.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_if.sv
// Valid/ready handshake bundle for the iterative RV32M multiply/divide unit.
// The master is the issuing pipeline stage; the slave is alu_muldiv.
interface alu_muldiv_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [2:0]      funct3;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] result;
    logic            zero;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output a, b, funct3, in_valid, out_ready,
        input  in_ready, result, zero, out_valid
    );

    modport slave (
        input  a, b, funct3, in_valid, out_ready,
        output in_ready, result, zero, out_valid
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fix-up folded into the final iteration.
module alu_muldiv #(
    parameter int SIZE      = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_muldiv_if.slave bus
);
    localparam int              CW      = $clog2(SIZE);
    localparam logic [CW-1:0]   LAST    = CW'(SIZE - 1);
    localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic            neg_q;
    logic            neg_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            zero_r;
    logic [SIZE-1:0] result_r;

    // hi/lo hold {partial product} for multiply and {remainder, quotient} for divide
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;
    logic [SIZE-1:0] opnd;

    function automatic logic [SIZE-1:0] cneg(input logic [SIZE-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*SIZE-1:0] cneg2(input logic [2*SIZE-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    logic            accept;
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic            b_zero;
    logic            div_ovf;
    logic            special;
    logic [SIZE-1:0] mag_a;
    logic [SIZE-1:0] mag_b;
    logic [SIZE-1:0] special_res;

    always_comb begin
        accept   = in_ready_r & bus.in_valid;
        a_signed = bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
        b_signed = bus.funct3 inside {3'd1, 3'd4, 3'd6};
        sa       = a_signed & bus.a[SIZE-1];
        sb       = b_signed & bus.b[SIZE-1];
        mag_a    = cneg(bus.a, sa);
        mag_b    = cneg(bus.b, sb);
        b_zero   = (bus.b == '0);
        div_ovf  = ~bus.funct3[0] && (bus.a == MIN_NEG) && (bus.b == '1);
        special  = FAST_DIV0 && bus.funct3[2] && (b_zero || div_ovf);
        // funct3[1] clear selects the quotient (DIV/DIVU), set selects the remainder
        if (!bus.funct3[1]) begin
            special_res = b_zero ? '1 : bus.a;
        end else begin
            special_res = b_zero ? bus.a : '0;
        end
    end

    logic [SIZE:0]     sum;
    logic [SIZE:0]     shifted;
    logic              ge;
    logic [SIZE-1:0]   diff;
    logic [SIZE-1:0]   hi_nx;
    logic [SIZE-1:0]   lo_nx;
    logic [2*SIZE-1:0] prod;
    logic [SIZE-1:0]   final_res;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(SIZE+1){1'b0}});
        shifted = {hi, lo[SIZE-1]};
        ge      = (shifted >= {1'b0, opnd});
        diff    = shifted[SIZE-1:0] - opnd;
        if (!op[2]) begin
            hi_nx = sum[SIZE:1];
            lo_nx = {sum[0], lo[SIZE-1:1]};
        end else begin
            hi_nx = ge ? diff : shifted[SIZE-1:0];
            lo_nx = {lo[SIZE-2:0], ge};
        end
        prod = cneg2({hi_nx, lo_nx}, neg_q);
        case (op)
            3'd0:       final_res = prod[SIZE-1:0];
            3'd1, 3'd2,
            3'd3:       final_res = prod[2*SIZE-1:SIZE];
            3'd4, 3'd5: final_res = cneg(lo_nx, neg_q);
            default:    final_res = cneg(hi_nx, neg_r);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            op          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op         <= bus.funct3;
                        count      <= '0;
                        neg_q      <= (sa ^ sb) & ~(bus.funct3[2] & b_zero);
                        neg_r      <= sa;
                        in_ready_r <= 1'b0;
                        if (special) begin
                            result_r    <= special_res;
                            zero_r      <= (special_res == '0);
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        result_r    <= final_res;
                        zero_r      <= (final_res == '0);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Iteration registers carry no reset: they are reloaded on every accept
    always_ff @(posedge clk) begin
        if (accept) begin
            hi <= '0;
            if (!bus.funct3[2]) begin
                lo   <= mag_b;
                opnd <= mag_a;
            end else begin
                lo   <= mag_a;
                opnd <= mag_b;
            end
        end else if (state == CALC) begin
            hi <= hi_nx;
            lo <= lo_nx;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
endmodule
